// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: bus addresses,
// control/status bit positions and the transmit state encoding.
package uart_pkg;

    localparam logic [31:0] ADDR_TXD_DEF = 32'h4000_0018;
    localparam logic [31:0] ADDR_CON_DEF = 32'h4000_0020;

    localparam int CON_IE      = 0;
    localparam int CON_DONE    = 1;
    localparam int CON_FULL    = 2;
    localparam int CON_BUSY    = 3;
    localparam int CON_CNT_LSB = 4;
    localparam int CON_OVF     = 7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Small synchronous byte FIFO feeding the UART serialiser. A push while full
// is still accepted when a pop happens in the same cycle.
module tx_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [7:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_responder.sv
// Bus-mapped 8N1 UART transmitter: CPU writes bytes into a TX FIFO and a
// bit-timer FSM shifts them out LSB first with a level frame-done interrupt.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// TX_IDLE  | line high, waiting for a byte in the FIFO
// TX_START | start bit (low) for CLKS_PER_BIT cycles
// TX_DATA  | data bit bit_idx for CLKS_PER_BIT cycles, LSB first
// TX_STOP  | stop bit (high); last cycle flags done and may chain next byte
module uart_tx_responder
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 5208,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] ADDR_TXD     = ADDR_TXD_DEF,
    parameter logic [31:0] ADDR_CON     = ADDR_CON_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        irq,
    output logic        tx_busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ie_q, ie_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic              wr_txd, wr_con;
    logic              fifo_push, fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [PTR_W:0]    fifo_count;
    logic              baud_last;
    logic              done_set;
    logic              ovf_set;
    logic [31:0]       con_val;
    logic              unused_wdata;

    assign wr_txd    = wr && (addr == ADDR_TXD);
    assign wr_con    = wr && (addr == ADDR_CON);
    assign fifo_push = wr_txd;
    assign ovf_set   = wr_txd && fifo_full && !fifo_pop;
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    assign uart_tx = tx_q;
    assign tx_busy = !fifo_empty || (state_q != TX_IDLE);
    assign irq     = ie_q && done_q;

    assign unused_wdata = ^{wdata[31:8], wdata[6:2]};

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Transmit FSM next-state; tx_d is the line level for the coming cycle.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        fifo_pop  = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = TX_START;
                    tx_d     = 1'b0;
                end
            end
            TX_START: begin
                tx_d   = 1'b0;
                baud_d = baud_q + BAUD_W'(1);
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                end
            end
            TX_DATA: begin
                tx_d   = shift_q[bit_idx_q];
                baud_d = baud_q + BAUD_W'(1);
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
            TX_STOP: begin
                tx_d   = 1'b1;
                baud_d = baud_q + BAUD_W'(1);
                if (baud_last) begin
                    baud_d   = '0;
                    done_set = 1'b1;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = TX_START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Control/status next-state; hardware sets take priority over W1C clears.
    always_comb begin
        ie_d   = ie_q;
        done_d = done_q;
        ovf_d  = ovf_q;
        if (wr_con) begin
            ie_d = wdata[CON_IE];
            if (wdata[CON_DONE]) done_d = 1'b0;
            if (wdata[CON_OVF])  ovf_d  = 1'b0;
        end
        if (done_set) done_d = 1'b1;
        if (ovf_set)  ovf_d  = 1'b1;
    end

    // Read mux for the control/status register.
    always_comb begin
        con_val                       = '0;
        con_val[CON_IE]               = ie_q;
        con_val[CON_DONE]             = done_q;
        con_val[CON_FULL]             = fifo_full;
        con_val[CON_BUSY]             = tx_busy;
        con_val[CON_CNT_LSB +: 3]     = 3'(fifo_count);
        con_val[CON_OVF]              = ovf_q;
        rdata = (rd && (addr == ADDR_CON)) ? con_val : 32'd0;
    end

    // FSM, serial line and control/status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ie_q      <= ie_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
